// File: rtl/padding_row_feeder_pkg.sv
// Shared constants and state encoding for the padding row feeder.
package padding_row_feeder_pkg;

  localparam int unsigned IMG_W    = 416;
  localparam int unsigned IMG_H    = 416;
  localparam int unsigned PIX_W    = 8;
  localparam int unsigned CNT_W    = 9;
  localparam int unsigned ROW_BITS = IMG_W * PIX_W;

  localparam logic [CNT_W-1:0] PAD_TOP_CNT = CNT_W'(0);
  localparam logic [CNT_W-1:0] PAD_BOT_CNT = CNT_W'(IMG_H + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TOP   = 3'd1,
    ST_FILL  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_BOT   = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/padding_row_feeder_if.sv
// Pixel-in / row-out bundle between the frame-buffer reader, the feeder and the padding stage.
interface padding_row_feeder_if;
  import padding_row_feeder_pkg::*;

  logic                start;
  logic                pix_valid;
  logic                pix_ready;
  logic [PIX_W-1:0]    pix_r;
  logic [PIX_W-1:0]    pix_g;
  logic [PIX_W-1:0]    pix_b;
  logic                row_ready;
  logic                en;
  logic                wait_en;
  logic [CNT_W-1:0]    count;
  logic [ROW_BITS-1:0] R_input;
  logic [ROW_BITS-1:0] G_input;
  logic [ROW_BITS-1:0] B_input;
  logic                busy;
  logic                done;

  // master: the feeder itself; slave: its environment
  modport master (
    input  start, pix_valid, pix_r, pix_g, pix_b, row_ready,
    output pix_ready, en, wait_en, count, R_input, G_input, B_input, busy, done
  );

  modport slave (
    output start, pix_valid, pix_r, pix_g, pix_b, row_ready,
    input  pix_ready, en, wait_en, count, R_input, G_input, B_input, busy, done
  );

endinterface

// File: rtl/padding_row_feeder_row_shift_buffer.sv
// One colour channel of the row buffer: pixels shift in at the LSB end; clear wins over shift.
module padding_row_feeder_row_shift_buffer
  import padding_row_feeder_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                shift_en,
  input  logic [PIX_W-1:0]    pix,
  output logic [ROW_BITS-1:0] row
);

  logic [ROW_BITS-1:0] row_q;
  logic [ROW_BITS-1:0] row_d;

  always_comb begin
    row_d = row_q;
    if (clr) begin
      row_d = '0;
    end else if (shift_en) begin
      row_d = {row_q[ROW_BITS-PIX_W-1:0], pix};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q <= '0;
    end else begin
      row_q <= row_d;
    end
  end

  assign row = row_q;

endmodule

// File: rtl/padding_row_feeder.sv
// Assembles pixel rows and issues them to the padding stage, framed by a zero top row and a zero bottom row.
module padding_row_feeder
  import padding_row_feeder_pkg::*;
#(
  parameter int unsigned FRAME_ROWS = IMG_H
) (
  input  logic                 clk,
  input  logic                 reset,
  padding_row_feeder_if.master bus
);

  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] ROWS_MAX = CNT_W'(FRAME_ROWS);
  localparam logic [CNT_W-1:0] BOT_CNT  = CNT_W'(FRAME_ROWS + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             buf_clr;
  logic             pix_fire;
  logic             pix_ready;
  logic             en;
  logic             busy;
  logic             done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pix_cnt_q <= '0;
      row_cnt_q <= '0;
      count_q   <= PAD_TOP_CNT;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      row_cnt_q <= row_cnt_d;
      count_q   <= count_d;
    end
  end

  // count and buffer contents are loaded on entry to TOP/ISSUE/BOT so they are stable through en
  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    row_cnt_d = row_cnt_q;
    count_d   = count_q;
    buf_clr   = 1'b0;
    pix_fire  = 1'b0;
    pix_ready = 1'b0;
    en        = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_TOP;
          buf_clr = 1'b1;
          count_d = PAD_TOP_CNT;
        end
      end
      ST_TOP: begin
        busy = 1'b1;
        if (bus.row_ready) begin
          en      = 1'b1;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        busy      = 1'b1;
        pix_ready = 1'b1;
        if (bus.pix_valid) begin
          pix_fire  = 1'b1;
          pix_cnt_d = pix_cnt_q + CNT_W'(1);
          if (pix_cnt_q == LAST_PIX) begin
            state_d = ST_ISSUE;
            count_d = row_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_ISSUE: begin
        busy = 1'b1;
        if (bus.row_ready) begin
          en        = 1'b1;
          pix_cnt_d = '0;
          if (row_cnt_q < ROWS_MAX) begin
            row_cnt_d = row_cnt_q + CNT_W'(1);
          end
          if ((row_cnt_q + CNT_W'(1)) < ROWS_MAX) begin
            state_d = ST_FILL;
          end else begin
            state_d = ST_BOT;
            buf_clr = 1'b1;
            count_d = BOT_CNT;
          end
        end
      end
      ST_BOT: begin
        busy = 1'b1;
        if (bus.row_ready) begin
          en      = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        pix_cnt_d = '0;
        row_cnt_d = '0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.pix_ready = pix_ready;
  assign bus.en        = en;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.wait_en   = busy & ~en;
  assign bus.count     = count_q;

  padding_row_feeder_row_shift_buffer u_row_r (
    .clk      (clk),
    .reset    (reset),
    .clr      (buf_clr),
    .shift_en (pix_fire),
    .pix      (bus.pix_r),
    .row      (bus.R_input)
  );

  padding_row_feeder_row_shift_buffer u_row_g (
    .clk      (clk),
    .reset    (reset),
    .clr      (buf_clr),
    .shift_en (pix_fire),
    .pix      (bus.pix_g),
    .row      (bus.G_input)
  );

  padding_row_feeder_row_shift_buffer u_row_b (
    .clk      (clk),
    .reset    (reset),
    .clr      (buf_clr),
    .shift_en (pix_fire),
    .pix      (bus.pix_b),
    .row      (bus.B_input)
  );

endmodule

// File: tb/tb_padding_row_feeder.sv
// Bench for padding_row_feeder: directed opening rows, then random frames against a row-level reference model.
module tb_padding_row_feeder;
  import padding_row_feeder_pkg::*;

  localparam int unsigned ROWS = 8;

  logic clk;
  logic reset;

  padding_row_feeder_if bus ();

  padding_row_feeder #(.FRAME_ROWS(ROWS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a frame is top pad, ROWS data rows of IMG_W accepted pixels, bottom pad
  logic [3*PIX_W-1:0] row_q[$];
  bit                 in_frame = 1'b0;
  bit                 done_due = 1'b0;
  int unsigned        next_cnt = 0;

  function automatic int row_diff(input bit pad);
    logic [3*PIX_W-1:0] a;
    logic [3*PIX_W-1:0] e;
    for (int i = 0; i < int'(IMG_W); i++) begin
      a = {bus.R_input[ROW_BITS-1-PIX_W*i -: PIX_W],
           bus.G_input[ROW_BITS-1-PIX_W*i -: PIX_W],
           bus.B_input[ROW_BITS-1-PIX_W*i -: PIX_W]};
      e = pad ? '0 : row_q[i];
      if (a !== e) return i;
    end
    return int'(IMG_W);
  endfunction

  initial begin : monitor
    bit pend, pad, e_en, e_busy, e_rdy, was_idle;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_frame = 1'b0;
        done_due = 1'b0;
        next_cnt = 0;
        row_q.delete();
      end else begin
        was_idle = !in_frame && !done_due;
        pad      = (next_cnt == 0) || (next_cnt == ROWS + 1);
        pend     = in_frame && !done_due && (pad || row_q.size() == IMG_W);
        e_en     = pend && bus.row_ready;
        e_busy   = in_frame && !done_due;
        e_rdy    = e_busy && next_cnt >= 1 && next_cnt <= ROWS && row_q.size() < IMG_W;
        check_eq("en", bus.en, e_en);
        check_eq("busy", bus.busy, e_busy);
        check_eq("done", bus.done, done_due);
        check_eq("pix_ready", bus.pix_ready, e_rdy);
        check_eq("wait_en", bus.wait_en, e_busy && !e_en);
        if (pend) begin
          check_eq("count", bus.count, next_cnt);
          check_eq("row_data_first_bad_pix", row_diff(pad), IMG_W);
        end
        if (e_en) begin
          next_cnt++;
          row_q.delete();
          if (next_cnt == ROWS + 2) done_due = 1'b1;
        end else if (done_due) begin
          done_due = 1'b0;
          in_frame = 1'b0;
        end
        if (e_rdy && bus.pix_valid) row_q.push_back({bus.pix_r, bus.pix_g, bus.pix_b});
        if (bus.start && was_idle) begin
          in_frame = 1'b1;
          next_cnt = 0;
          row_q.delete();
        end
      end
    end
  end

  // Stimulus knobs and per-cycle snapshots
  int unsigned valid_pct = 0;
  int unsigned rr_pct    = 0;
  bit          pat_mode  = 1'b0;
  bit          start_req = 1'b0;
  int unsigned pat_idx   = 0;
  int unsigned acc       = 0;
  int unsigned en_seen   = 0;
  int unsigned done_seen = 0;
  int          last_cnt  = -1;

  logic             s_en, s_rdy, s_wait, s_busy, s_done, s_nz;
  logic [CNT_W-1:0] s_cnt;
  logic [PIX_W-1:0] s_r_hi, s_r_lo, s_g_hi, s_g_lo, s_b_lo;

  task automatic step();
    bus.start     = start_req;
    start_req     = 1'b0;
    bus.pix_valid = ($urandom_range(99) < valid_pct);
    bus.row_ready = ($urandom_range(99) < rr_pct);
    if (pat_mode) begin
      bus.pix_r = 8'(pat_idx % 256);
      bus.pix_g = 8'(255 - (pat_idx % 256));
      bus.pix_b = 8'hA5;
    end else begin
      bus.pix_r = 8'($urandom);
      bus.pix_g = 8'($urandom);
      bus.pix_b = 8'($urandom);
    end
    @(negedge clk);
    s_en   = bus.en;
    s_rdy  = bus.pix_ready;
    s_wait = bus.wait_en;
    s_busy = bus.busy;
    s_done = bus.done;
    s_cnt  = bus.count;
    s_nz   = (|bus.R_input) | (|bus.G_input) | (|bus.B_input);
    s_r_hi = bus.R_input[ROW_BITS-1 -: PIX_W];
    s_g_hi = bus.G_input[ROW_BITS-1 -: PIX_W];
    s_r_lo = bus.R_input[PIX_W-1:0];
    s_g_lo = bus.G_input[PIX_W-1:0];
    s_b_lo = bus.B_input[PIX_W-1:0];
    if (bus.pix_valid && bus.pix_ready) begin
      pat_idx++;
      acc++;
    end
    if (bus.en) begin
      en_seen++;
      last_cnt = int'(bus.count);
      acc      = 0;
    end
    if (bus.done) done_seen++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_done();
    int guard;
    guard = 0;
    while (done_seen == 0 && guard < 20000) begin
      step();
      guard++;
    end
  endtask

  initial begin : stim
    int  guard;
    bit  poked;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.pix_valid = 1'b0;
    bus.row_ready = 1'b0;
    bus.pix_r     = '0;
    bus.pix_g     = '0;
    bus.pix_b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_en", bus.en, 0);
    check_eq("rst_pix_ready", bus.pix_ready, 0);
    check_eq("rst_wait_en", bus.wait_en, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_count", bus.count, 0);
    check_eq("rst_rows_nonzero", (|bus.R_input) | (|bus.G_input) | (|bus.B_input), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Frame 1: top pad timing, directed first row, stalled second row
    en_seen = 0; done_seen = 0;
    valid_pct = 0; rr_pct = 100; start_req = 1'b1;
    step();
    check_eq("start_cycle_en", s_en, 0);
    step();
    check_eq("top_en", s_en, 1);
    check_eq("top_count", s_cnt, 0);
    check_eq("top_rows_nonzero", s_nz, 0);
    pat_mode = 1'b1; pat_idx = 0; valid_pct = 100;
    step();
    check_eq("fill_pix_ready", s_rdy, 1);
    guard = 0;
    while (pat_idx < IMG_W && guard < 600) begin step(); guard++; end
    check_eq("row1_pixels", pat_idx, IMG_W);
    step();
    check_eq("row1_en_latency", s_en, 1);
    check_eq("row1_count", s_cnt, 1);
    check_eq("row1_issue_pix_ready", s_rdy, 0);
    check_eq("row1_r_first", s_r_hi, 8'h00);
    check_eq("row1_g_first", s_g_hi, 8'hFF);
    check_eq("row1_r_last", s_r_lo, 8'h9F);
    check_eq("row1_g_last", s_g_lo, 8'h60);
    check_eq("row1_b_last", s_b_lo, 8'hA5);
    check_eq("row1_issue_no_take", pat_idx, IMG_W);

    pat_idx = 0; poked = 1'b0; guard = 0;
    while (pat_idx < IMG_W && guard < 600) begin
      if (pat_idx == 100 && !poked) begin start_req = 1'b1; poked = 1'b1; end
      step();
      guard++;
    end
    check_eq("row2_pixels", pat_idx, IMG_W);
    rr_pct = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("stall_en", s_en, 0);
      check_eq("stall_wait_en", s_wait, 1);
      check_eq("stall_count", s_cnt, 2);
      check_eq("stall_r_last", s_r_lo, 8'h9F);
    end
    check_eq("stall_no_take", pat_idx, IMG_W);
    rr_pct = 100;
    step();
    check_eq("row2_release_en", s_en, 1);
    check_eq("row2_count", s_cnt, 2);

    pat_mode = 1'b0; valid_pct = 60; rr_pct = 70;
    run_to_done();
    check_eq("frame1_done", done_seen, 1);
    check_eq("frame1_en_pulses", en_seen, ROWS + 2);

    // Frame 2: fully random gaps and stalls
    en_seen = 0; done_seen = 0; start_req = 1'b1;
    run_to_done();
    repeat (5) step();
    check_eq("frame2_done", done_seen, 1);
    check_eq("frame2_en_pulses", en_seen, ROWS + 2);

    // Frame 3: reset in the middle of row 5, then restart
    en_seen = 0; done_seen = 0; last_cnt = -1; start_req = 1'b1; guard = 0;
    while (!(last_cnt == 4 && acc == 200) && guard < 20000) begin step(); guard++; end
    check_eq("mid_row_reset_point", acc, 200);
    reset = 1'b1;
    step();
    reset = 1'b0; valid_pct = 100; rr_pct = 100;
    step();
    check_eq("abort_en", s_en, 0);
    check_eq("abort_busy", s_busy, 0);
    check_eq("abort_pix_ready", s_rdy, 0);
    check_eq("abort_wait_en", s_wait, 0);
    check_eq("abort_done", s_done, 0);
    check_eq("abort_count", s_cnt, 0);
    check_eq("abort_rows_nonzero", s_nz, 0);
    start_req = 1'b1;
    step();
    step();
    check_eq("restart_en", s_en, 1);
    check_eq("restart_count", s_cnt, 0);
    en_seen = 1; done_seen = 0; valid_pct = 75; rr_pct = 80;
    run_to_done();
    check_eq("frame3_done", done_seen, 1);
    check_eq("frame3_en_pulses", en_seen, ROWS + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
